// File: rtl/gte_pkg.sv
// Shared constants for the race-logic greater-or-equal comparator.
// GTE_FALLING_EN selects idle-high / falling-edge event polarity.
package gte_pkg;

  localparam int GAMMA_CYCLE_WIDTH_DEF = 16;

`ifdef GTE_FALLING_EN
  localparam logic EVT_INV = 1'b1;
`else
  localparam logic EVT_INV = 1'b0;
`endif

  function automatic int time_w(input int gamma);
    return (gamma > 1) ? $clog2(gamma) : 1;
  endfunction

endpackage

// File: rtl/race_arrival_latch.sv
// Captures the first arrival of one event wire within a gamma cycle:
// sticky seen flag, single-cycle first strobe and the arrival time stamp.
module race_arrival_latch #(
  parameter int                TIME_W  = 4,
  parameter logic [TIME_W-1:0] CNT_MAX = '1
) (
  input  logic              aclk,
  input  logic              rst,
  input  logic              grst,
  input  logic              sig,
  input  logic [TIME_W-1:0] cnt,
  output logic              seen,
  output logic              first,
  output logic [TIME_W-1:0] t_arr
);

  // arrivals in the last slot of the gamma cycle are too late to count
  assign first = sig & ~seen & (cnt != CNT_MAX);

  always_ff @(posedge aclk) begin
    if (!rst || !grst) begin
      seen  <= 1'b0;
      t_arr <= '0;
    end else if (first) begin
      seen  <= 1'b1;
      t_arr <= cnt;
    end
  end

endmodule

// File: rtl/greater_than_eq.sv
// Race-logic comparator: q forwards a's event only when a arrives no earlier than b.
// Define GTE_FALLING_EN for idle-high inputs/output with falling-edge events.
module greater_than_eq
  import gte_pkg::*;
#(
  parameter  int GAMMA_CYCLE_WIDTH = GAMMA_CYCLE_WIDTH_DEF,
  localparam int TIME_W            = time_w(GAMMA_CYCLE_WIDTH)
) (
  input  logic              aclk,
  input  logic              rst,
  input  logic              grst,
  input  logic              a,
  input  logic              b,
  output logic              q,
  output logic [TIME_W-1:0] q_time,
  output logic              done
);

  localparam logic [TIME_W-1:0] CNT_MAX = TIME_W'(GAMMA_CYCLE_WIDTH - 1);

  logic [TIME_W-1:0] cnt;
  logic              a_evt, b_evt;
  logic              a_seen, a_first, b_seen, b_first;
  logic [TIME_W-1:0] a_t_arr, b_t_arr;
  logic              q_r, armed, fire;

  assign a_evt = a ^ EVT_INV;
  assign b_evt = b ^ EVT_INV;

  race_arrival_latch #(.TIME_W(TIME_W), .CNT_MAX(CNT_MAX)) u_lat_a (
    .aclk (aclk), .rst (rst), .grst (grst), .sig (a_evt), .cnt (cnt),
    .seen (a_seen), .first (a_first), .t_arr (a_t_arr)
  );

  race_arrival_latch #(.TIME_W(TIME_W), .CNT_MAX(CNT_MAX)) u_lat_b (
    .aclk (aclk), .rst (rst), .grst (grst), .sig (b_evt), .cnt (cnt),
    .seen (b_seen), .first (b_first), .t_arr (b_t_arr)
  );

  // a wins the race for q if b lands in the same sample or already landed earlier
  assign fire = a_first & (b_first | (b_seen & (b_t_arr <= cnt)));

  always_ff @(posedge aclk) begin
    if (!rst || !grst) begin
      cnt   <= '0;
      q_r   <= 1'b0;
      armed <= 1'b0;
    end else begin
      if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
      if (fire) begin
        q_r   <= 1'b1;
        armed <= 1'b1;
      end else if (armed && !a_evt) begin
        q_r   <= 1'b0;
        armed <= 1'b0;
      end
    end
  end

  assign q      = q_r ^ EVT_INV;
  assign q_time = (armed && a_seen) ? a_t_arr : '0;
  assign done   = (cnt == CNT_MAX);

endmodule

// File: tb/tb_greater_than_eq.sv
// Bench for greater_than_eq: arrival-time reference model plus directed
// test-plan scenarios and randomized races, checked every cycle.
module tb_greater_than_eq;

  localparam int G  = 16;
  localparam int TW = 4;
`ifdef GTE_FALLING_EN
  localparam logic POL = 1'b1;
`else
  localparam logic POL = 1'b0;
`endif

  logic          aclk = 1'b0;
  logic          rst  = 1'b0;
  logic          grst = 1'b1;
  logic          a_l  = 1'b0;
  logic          b_l  = 1'b0;
  logic          a, b, q, done;
  logic [TW-1:0] q_time;

  assign a = a_l ^ POL;
  assign b = b_l ^ POL;

  always #5 aclk = ~aclk;

  greater_than_eq #(.GAMMA_CYCLE_WIDTH(G)) dut (
    .aclk (aclk), .rst (rst), .grst (grst), .a (a), .b (b),
    .q (q), .q_time (q_time), .done (done)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // reference model: edges since release, arrival times, and whether a's pulse is still live
  int k  = 0;
  int ta = -1;
  int tb = -1;
  bit run = 0;
  bit started = 0;

  always @(posedge aclk) begin
    int cur;
    if (!rst || !grst) begin
      k = 0; ta = -1; tb = -1; run = 0;
    end else begin
      cur = (k < G - 1) ? k : G - 1;
      if (b_l && tb < 0 && cur < G - 1) tb = cur;
      if (a_l && ta < 0 && cur < G - 1) begin
        ta  = cur;
        run = (tb >= 0);
      end else if (!a_l) begin
        run = 0;
      end
      if (k < G) k++;
    end
  end

  int   cyc = -1;
  logic obs_q    [0:63];
  int   obs_qt   [0:63];
  logic obs_done [0:63];

  always @(negedge aclk) begin
    if (started) begin
      chk("q", 32'(q ^ POL), 32'(run));
      chk("q_time", 32'(q_time), run ? ta : 0);
      chk("done", 32'(done), 32'(k >= G - 1));
      if (cyc >= 0 && cyc < 64) begin
        obs_q[cyc]    = q ^ POL;
        obs_qt[cyc]   = int'(q_time);
        obs_done[cyc] = done;
      end
    end
  end

  int ar, af, br, bf, gl, md;

  task automatic drive(input int c);
    if (md != 0) begin
      a_l = 1'($urandom % 2);
      b_l = 1'($urandom % 2);
    end else begin
      a_l = (c >= ar) && (c < af);
      b_l = (c >= br) && (c < bf);
    end
    grst = (c != gl);
  endtask

  task automatic run_case(input int a_r, input int a_f, input int b_r, input int b_f,
                          input int g_l, input int mode, input int n);
    ar = a_r; af = a_f; br = b_r; bf = b_f; gl = g_l; md = mode;
    rst = 1'b0; grst = 1'b1; a_l = 1'b0; b_l = 1'b0; cyc = -1;
    @(posedge aclk); #1;
    started = 1;
    rst = 1'b1;
    for (int c = 0; c < n; c++) begin
      cyc = c;
      drive(c);
      @(posedge aclk); #1;
    end
    cyc = -1;
  endtask

  initial begin
    // no events at all
    run_case(99, 99, 99, 99, 99, 0, 20);
    chk("idle_q15", 32'(obs_q[15]), 0);
    chk("idle_qt10", obs_qt[10], 0);
    chk("idle_done14", 32'(obs_done[14]), 0);
    chk("idle_done15", 32'(obs_done[15]), 1);

    // a before b: never fires
    run_case(2, 8, 4, 10, 99, 0, 20);
    chk("a_first_q5", 32'(obs_q[5]), 0);
    chk("a_first_q9", 32'(obs_q[9]), 0);

    // b before a: q mirrors a one cycle late
    run_case(4, 10, 2, 8, 99, 0, 20);
    chk("b_first_q4", 32'(obs_q[4]), 0);
    chk("b_first_q5", 32'(obs_q[5]), 1);
    chk("b_first_q10", 32'(obs_q[10]), 1);
    chk("b_first_q11", 32'(obs_q[11]), 0);
    chk("b_first_qt5", obs_qt[5], 4);
    chk("b_first_qt11", obs_qt[11], 0);

    // simultaneous arrival
    run_case(2, 8, 2, 8, 99, 0, 20);
    chk("tie_q2", 32'(obs_q[2]), 0);
    chk("tie_q3", 32'(obs_q[3]), 1);
    chk("tie_q8", 32'(obs_q[8]), 1);
    chk("tie_q9", 32'(obs_q[9]), 0);
    chk("tie_qt3", obs_qt[3], 2);

    // gamma restart mid-pulse
    run_case(4, 10, 2, 8, 7, 0, 20);
    chk("grst_q7", 32'(obs_q[7]), 1);
    chk("grst_q8", 32'(obs_q[8]), 0);
    chk("grst_q9", 32'(obs_q[9]), 0);
    chk("grst_done15", 32'(obs_done[15]), 0);

    // last usable slot vs. timeout slot
    run_case(14, 18, 14, 18, 99, 0, 20);
    chk("late_q15", 32'(obs_q[15]), 1);
    chk("late_qt15", obs_qt[15], 14);
    run_case(15, 18, 15, 18, 99, 0, 20);
    chk("timeout_q16", 32'(obs_q[16]), 0);
    chk("timeout_q17", 32'(obs_q[17]), 0);

    // randomized races
    for (int i = 0; i < 60; i++) begin
      int r_a, r_b;
      r_a = int'($urandom_range(0, 17));
      r_b = int'($urandom_range(0, 17));
      run_case(r_a, r_a + 1 + int'($urandom % 8), r_b, r_b + 1 + int'($urandom % 8),
               int'($urandom % 40), int'($urandom % 4 == 0), 20);
    end

    started = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/greater_than_eq.md
Name: greater_than_eq

Overview:
- Clocked race-logic (temporal) comparator: operands encoded as arrival time of a rising edge within a gamma cycle; earlier arrival = smaller value.
- Output q passes input a's event through only when value(a) >= value(b), i.e. a arrives in the same sample as b or later; otherwise q stays idle for the whole gamma cycle.
- Sits in the temporal-compute datapath alongside other race-logic primitives, sharing the gamma-cycle restart grst.

Parameters:
- GAMMA_CYCLE_WIDTH, 16, gamma cycle length in aclk cycles; the time counter saturates at GAMMA_CYCLE_WIDTH-1.
- TIME_W, $clog2(GAMMA_CYCLE_WIDTH), width of the time stamps (localparam, derived, not overridable).

Ports:
- aclk  in  1  single clock; all logic on posedge.
- rst  in  1  synchronous, active-low reset; clears all state.
- grst  in  1  synchronous, active-low gamma-cycle restart; same clearing effect as rst, plus restarts the time counter.
- a  in  1  operand A event wire; synchronous to aclk; idle low, event = rising level.
- b  in  1  operand B event wire; same coding as a.
- q  out  1  result event; rises iff a arrives no earlier than b; then mirrors a's pulse width.
- q_time  out  TIME_W  counter value sampled when a arrived; valid while q=1; 0 otherwise.
- done  out  1  high while the time counter equals GAMMA_CYCLE_WIDTH-1.

Behaviour:
- Reset: on any edge with rst=0 or grst=0, the following clear next edge: q=0, q_time=0, done=0, counter=0, arrival flags a_seen=0 and b_seen=0, armed=0.
- Counter:
  - On the first edge with both rst and grst high, it goes to 1.
  - It increments every edge after that, saturating at GAMMA_CYCLE_WIDTH-1.
  - Cycle n means the n-th edge after release; the release edge itself is cycle 0.
- Arrival detection:
  - a_seen is set at the first edge where a is sampled 1.
  - b_seen is set the same way for b.
  - Both flags are sticky until reset or grst.
  - Arrival time is the counter value at that edge.
- Comparison at the edge where a first samples 1:
  - If b samples 1 at the same edge, or b_seen is already set: q becomes 1 at that edge (visible next cycle), armed=1, and q_time latches the counter.
  - Otherwise: q is never asserted for the rest of the gamma cycle, regardless of later b.
- Pulse tracking:
  - While armed, q follows the registered a: q falls at the first edge a samples 0.
  - After that fall, armed=0 and there is no re-fire, even if a re-rises, until grst or rst.
- Latency: q is one-register delayed from a in both directions (rise and fall).
- b's fall has no effect on q.
- Timeout: arrivals first sampled while counter = GAMMA_CYCLE_WIDTH-1 (done=1) are ignored.
- Neither input arriving: q stays 0 and q_time stays 0.
- grst or rst asserted mid-pulse: q drops to 0 at that edge regardless of a.

Optional Feature:
- GTE_FALLING_EN defined:
  - Inputs and q use inverted polarity: idle 1, event = falling level.
  - Reset drives q=1.
  - a and b are internally inverted before detection, and q is inverted on output.
- Not defined: rising polarity as above.
- q_time and done are unaffected by the macro.

Decomposition:
- Package gte_pkg:
  - GAMMA_CYCLE_WIDTH default constant.
  - TIME_W function or localparam.
  - Event-polarity constant selected by GTE_FALLING_EN.
- One sub-module race_arrival_latch, instantiated twice (for a and b):
  - Inputs: aclk, rst, grst, sig, cnt.
  - Outputs: seen, first (single-cycle arrival strobe), t_arr.
- Comparator, armed/q logic and time counter live in the top module.

Test Plan (GAMMA_CYCLE_WIDTH=16):
- No events across a full 16-cycle gamma cycle -> q=0 and q_time=0 throughout; done=1 from cycle 15.
- a rises at cycle 2, b at cycle 4; a falls at 8, b at 10 -> q never asserts.
- b rises at cycle 2, a at 4; b falls at 8, a falls at 10 -> q=1 visible during cycles 5..10, falls after edge 10; q_time=4.
- a and b both rise at cycle 2, both fall at 8 -> q=1 visible cycles 3..8; q_time=2.
- Case 3 stimulus with grst pulsed low at cycle 7 -> q=0 from cycle 8; no re-fire while a is still high; counter restarts at 0.
- GTE_FALLING_EN defined, idle-high inputs, b falls at 2, a falls at 4 -> q falls low cycle 5 and returns high after a returns high; a falls first -> q stays 1.
